// File: rtl/memio_responder.sv
// ---------------------------------------------------------------------------
// memio_responder
//   Memory-side responder for the mips core's data port. Holds the data
//   memory and a small memory-mapped I/O block: keyboard scan-code FIFO,
//   16-bit LED register and a free-running cycle counter.
//
//   Loads are combinational from mem_addr and current state; stores, FIFO
//   pops and counter updates happen on the rising clock edge while
//   enable=1. Keyboard pushes are accepted regardless of enable.
//
// Ports
//   clk            in   1      system clock, rising edge
//   reset          in   1      asynchronous, active-low
//   enable         in   1      processor enable; 0 freezes core-side updates
//   mem_wr         in   1      store strobe
//   mem_rd         in   1      load strobe (gates read side effects)
//   mem_addr       in   32     byte address, bits[1:0] ignored
//   mem_writedata  in   Dbits  store data
//   mem_readdata   out  Dbits  load data (combinational)
//   key_valid      in   1      keyboard push strobe
//   key_code       in   8      scan code pushed with key_valid
//   leds           out  16     LED register contents
// ---------------------------------------------------------------------------
module memio_responder #(
    parameter int          Dbits     = 32,
    parameter int          Nwords    = 64,
    parameter int          Kdepth    = 4,
    parameter logic [31:0] DMEM_BASE = 32'h1001_0000,
    parameter logic [31:0] IO_BASE   = 32'h1002_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             mem_wr,
    input  logic             mem_rd,
    input  logic [31:0]      mem_addr,
    input  logic [Dbits-1:0] mem_writedata,
    output logic [Dbits-1:0] mem_readdata,
    input  logic             key_valid,
    input  logic [7:0]       key_code,
    output logic [15:0]      leds
);

    localparam int AW = $clog2(Nwords);
    localparam int KW = $clog2(Kdepth);
    // Count needs one more bit than the pointers to represent "full".
    localparam int CW = KW + 1;

    typedef enum logic [1:0] {
        REG_STATUS = 2'd0,
        REG_DATA   = 2'd1,
        REG_LED    = 2'd2,
        REG_CYCLES = 2'd3
    } io_reg_e;

    // State
    logic [Dbits-1:0] dmem_r [Nwords];
    logic [7:0]       fifo_r [Kdepth];
    logic [KW-1:0]    rd_ptr_r;
    logic [KW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;
    logic             ovf_r;
    logic [15:0]      leds_r;
    logic [31:0]      cycles_r;

    // Decode
    logic [31:0]      dm_off_s;
    logic             dm_hit_s;
    logic [AW-1:0]    dm_idx_s;
    logic             io_hit_s;
    io_reg_e          reg_sel_s;
    logic             unused_s;

    // Strobes
    logic             rd_fx_s;
    logic             wr_s;
    logic             empty_s;
    logic             full_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic             ovf_clr_s;
    logic             cyc_clr_s;
    logic             led_wr_s;
    logic             dm_wr_s;

    logic [7:0]       head_s;
    logic [Dbits-1:0] status_s;
    logic [Dbits-1:0] rdata_s;

    // Unsigned offset from DMEM_BASE: anything below the base wraps to a
    // large value and so falls outside the window as well.
    assign dm_off_s  = mem_addr - DMEM_BASE;
    assign dm_hit_s  = (dm_off_s[31:AW+2] == '0);
    assign dm_idx_s  = dm_off_s[AW+1:2];
    assign io_hit_s  = (mem_addr[31:4] == IO_BASE[31:4]);
    assign reg_sel_s = io_reg_e'(mem_addr[3:2]);
    assign unused_s  = ^{mem_addr[1:0], dm_off_s[1:0]};

    // A simultaneous store suppresses all load side effects.
    assign rd_fx_s   = enable & mem_rd & ~mem_wr;
    assign wr_s      = enable & mem_wr;

    assign empty_s   = (count_r == {CW{1'b0}});
    assign full_s    = (count_r == CW'(Kdepth));
    assign pop_s     = rd_fx_s & io_hit_s & (reg_sel_s == REG_DATA) & ~empty_s;
    // A pop in the same edge frees the slot the push needs.
    assign push_s    = key_valid & (~full_s | pop_s);
    assign drop_s    = key_valid & full_s & ~pop_s;
    assign ovf_clr_s = rd_fx_s & io_hit_s & (reg_sel_s == REG_STATUS);
    assign cyc_clr_s = wr_s & io_hit_s & (reg_sel_s == REG_CYCLES);
    assign led_wr_s  = wr_s & io_hit_s & (reg_sel_s == REG_LED);
    assign dm_wr_s   = wr_s & dm_hit_s;

    assign head_s    = empty_s ? 8'h00 : fifo_r[rd_ptr_r];

    // KEY_STATUS layout: [0]=nonempty, [CW:1]=count, [8]=overflow.
    always_comb begin
        status_s       = '0;
        status_s[0]    = ~empty_s;
        status_s[CW:1] = count_r;
        status_s[8]    = ovf_r;
    end

    // Load data mux over the address map; unmapped addresses read 0.
    always_comb begin
        rdata_s = '0;
        if (dm_hit_s) begin
            rdata_s = dmem_r[dm_idx_s];
        end else if (io_hit_s) begin
            case (reg_sel_s)
                REG_STATUS: rdata_s = status_s;
                REG_DATA:   rdata_s = Dbits'(head_s);
                REG_LED:    rdata_s = Dbits'(leds_r);
                REG_CYCLES: rdata_s = Dbits'(cycles_r);
                default:    rdata_s = '0;
            endcase
        end else begin
            rdata_s = '0;
        end
    end

    assign mem_readdata = rdata_s;
    assign leds         = leds_r;

    // Data memory array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (dm_wr_s) begin
            dmem_r[dm_idx_s] <= mem_writedata;
        end
    end

    // FIFO storage; only slots behind the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_r[wr_ptr_r] <= key_code;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_r <= {KW{1'b0}};
            wr_ptr_r <= {KW{1'b0}};
            count_r  <= {CW{1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + KW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + KW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            // A drop in the same edge as a status read leaves the flag set.
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr_s) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // LED register and cycle counter; a CYCLES store beats the increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            leds_r   <= 16'h0000;
            cycles_r <= 32'h0000_0000;
        end else begin
            if (led_wr_s) begin
                leds_r <= mem_writedata[15:0];
            end
            if (cyc_clr_s) begin
                cycles_r <= 32'h0000_0000;
            end else if (enable) begin
                cycles_r <= cycles_r + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_memio_responder.sv
// ---------------------------------------------------------------------------
// tb_memio_responder
//   Directed-vector bench for memio_responder. The driver pushes the
//   hand-computed expected load data (and LED value) into queues as it
//   issues each bus cycle; a monitor on the falling edge pops and compares
//   whenever a load or LED check is presented.
// ---------------------------------------------------------------------------
module tb_memio_responder;

    localparam logic [31:0] DM = 32'h1001_0000;
    localparam logic [31:0] IO = 32'h1002_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        mem_wr;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        key_valid;
    logic [7:0]  key_code;
    logic [15:0] leds;

    logic [31:0] rd_q [$];
    string       nm_q [$];
    logic [15:0] led_q [$];
    logic        led_chk = 1'b0;
    logic        done = 1'b0;
    logic        done_chk = 1'b0;
    int          errors = 0;
    int          checks = 0;

    memio_responder dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .mem_wr        (mem_wr),
        .mem_rd        (mem_rd),
        .mem_addr      (mem_addr),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .leds          (leds)
    );

    always #5 clk = ~clk;

    // Monitor: compare presented outputs against queued expectations.
    always @(negedge clk) begin
        if (mem_rd) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_load: got %h required no load", mem_readdata);
            end else begin
                logic [31:0] e;
                string       n;
                e = rd_q.pop_front();
                n = nm_q.pop_front();
                if (mem_readdata !== e) begin
                    errors++;
                    $display("FAIL %s: got %h required %h", n, mem_readdata, e);
                end
            end
        end
        if (led_chk) begin
            checks++;
            if (led_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_led_check: got %h", leds);
            end else begin
                logic [15:0] le;
                le = led_q.pop_front();
                if (leds !== le) begin
                    errors++;
                    $display("FAIL leds: got %h required %h", leds, le);
                end
            end
        end
        if (done && !done_chk) begin
            done_chk = 1'b1;
            checks++;
            if (rd_q.size() != 0 || led_q.size() != 0) begin
                errors++;
                $display("FAIL leftover_expectations: got %0d required 0",
                         rd_q.size() + led_q.size());
            end
        end
    end

    // One bus cycle: inputs applied just after a rising edge, held until the next.
    task automatic cyc(input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [31:0] wd, input logic kv, input logic [7:0] kc,
                       input logic [31:0] exp_rd, input string nm);
        mem_wr        = wr;
        mem_rd        = rd;
        mem_addr      = addr;
        mem_writedata = wd;
        key_valid     = kv;
        key_code      = kc;
        if (rd) begin
            rd_q.push_back(exp_rd);
            nm_q.push_back(nm);
        end
        @(posedge clk);
        #1;
        mem_wr    = 1'b0;
        mem_rd    = 1'b0;
        key_valid = 1'b0;
        led_chk   = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00, 32'h0, "");
    endtask

    task automatic ld(input logic [31:0] addr, input logic [31:0] e, input string nm);
        cyc(1'b0, 1'b1, addr, 32'h0, 1'b0, 8'h00, e, nm);
    endtask

    task automatic st(input logic [31:0] addr, input logic [31:0] d);
        cyc(1'b1, 1'b0, addr, d, 1'b0, 8'h00, 32'h0, "");
    endtask

    task automatic push(input logic [7:0] c);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, c, 32'h0, "");
    endtask

    task automatic expect_leds(input logic [15:0] v);
        led_q.push_back(v);
        led_chk = 1'b1;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0;
        mem_wr = 1'b0; mem_rd = 1'b0; mem_addr = 32'h0; mem_writedata = 32'h0;
        key_valid = 1'b0; key_code = 8'h00;
        @(posedge clk); #1;

        // Reset state
        expect_leds(16'h0000);
        ld(IO + 32'h0, 32'h0, "rst_status");
        ld(IO + 32'hC, 32'h0, "rst_cycles");
        ld(IO + 32'h8, 32'h0, "rst_led");

        // Cycle counter: 10 enabled edges, then store-clear
        reset = 1'b1; enable = 1'b1;
        for (int i = 0; i < 10; i++) idle();
        ld(IO + 32'hC, 32'd10, "cycles_10");          // -> 11 after edge
        st(IO + 32'hC, 32'hFFFF_FFFF);                // cleared at edge
        ld(IO + 32'hC, 32'd0, "cycles_cleared");      // -> 1

        // Data memory
        st(DM + 32'h10, 32'hDEAD_BEEF);               // -> 2
        ld(DM + 32'h10, 32'hDEAD_BEEF, "dmem_rw");    // -> 3
        st(DM + 32'h14, 32'h1111_1111);               // -> 4
        enable = 1'b0;
        st(DM + 32'h14, 32'h2222_2222);
        ld(IO + 32'hC, 32'd4, "cycles_frozen");
        enable = 1'b1;
        ld(DM + 32'h14, 32'h1111_1111, "dmem_en0_store");
        st(DM + 32'h00, 32'hA5A5_A5A5);
        st(DM + 32'hFC, 32'h0BAD_CAFE);
        st(DM + 32'h100, 32'h0000_0BAD);              // past the end: ignored
        ld(DM + 32'hFC, 32'h0BAD_CAFE, "dmem_last");
        ld(DM + 32'h100, 32'h0, "dmem_past_end");
        ld(DM + 32'h00, 32'hA5A5_A5A5, "dmem_no_alias");

        // Keyboard FIFO basics
        push(8'h1C);
        push(8'h32);
        ld(IO + 32'h0, 32'h5, "status_two");
        ld(IO + 32'h4, 32'h1C, "pop_first");
        ld(IO + 32'h4, 32'h32, "pop_second");
        ld(IO + 32'h4, 32'h0, "pop_empty");
        ld(IO + 32'h0, 32'h0, "status_empty");

        // Address KEY_DATA without mem_rd: no pop
        push(8'h44);
        cyc(1'b0, 1'b0, IO + 32'h4, 32'h0, 1'b0, 8'h00, 32'h0, "");
        ld(IO + 32'h0, 32'h3, "status_no_pop");
        ld(IO + 32'h4, 32'h44, "pop_44");

        // Pop on empty with simultaneous push
        cyc(1'b0, 1'b1, IO + 32'h4, 32'h0, 1'b1, 8'h55, 32'h0, "pop_empty_push");
        ld(IO + 32'h0, 32'h3, "status_after_empty_push");
        ld(IO + 32'h4, 32'h55, "pop_55");

        // Store and load together: store wins, no pop
        push(8'h66);
        cyc(1'b1, 1'b1, IO + 32'h4, 32'h0, 1'b0, 8'h00, 32'h66, "wr_rd_data");
        ld(IO + 32'h0, 32'h3, "status_wr_rd");
        ld(IO + 32'h4, 32'h66, "pop_66");

        // Overflow and full-FIFO pop+push
        for (int i = 1; i <= 5; i++) push(8'(i));
        ld(IO + 32'h0, 32'h109, "status_overflow");
        ld(IO + 32'h0, 32'h009, "status_ovf_cleared");
        cyc(1'b0, 1'b1, IO + 32'h4, 32'h0, 1'b1, 8'h06, 32'h01, "pop_push_full");
        ld(IO + 32'h0, 32'h009, "status_full_kept");
        ld(IO + 32'h4, 32'h02, "order_02");
        ld(IO + 32'h4, 32'h03, "order_03");
        ld(IO + 32'h4, 32'h04, "order_04");
        ld(IO + 32'h4, 32'h06, "order_06");
        ld(IO + 32'h0, 32'h0, "status_drained");

        // Drop during status read: set wins over clear
        for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
        cyc(1'b0, 1'b1, IO + 32'h0, 32'h0, 1'b1, 8'h77, 32'h009, "status_drop_same");
        ld(IO + 32'h0, 32'h109, "ovf_set_wins");

        // LEDs
        st(IO + 32'h8, 32'h0001_ABCD);
        expect_leds(16'hABCD);
        ld(IO + 32'h8, 32'h0000_ABCD, "led_read");

        // Reset mid-operation: immediate effect
        reset = 1'b0;
        #1;
        expect_leds(16'h0000);
        ld(IO + 32'h0, 32'h0, "status_after_reset");
        reset = 1'b1;
        ld(IO + 32'hC, 32'h0, "cycles_after_reset");  // -> 1
        ld(IO + 32'hC, 32'h1, "cycles_resume");
        ld(DM + 32'h10, 32'hDEAD_BEEF, "dmem_survives_reset");

        // Unmapped
        st(32'h0040_0000, 32'h1234_5678);
        ld(32'h0040_0000, 32'h0, "unmapped");
        ld(IO + 32'h10, 32'h0, "io_unmapped");

        done = 1'b1;
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
